// File: rtl/port_bus_sequencer_if.sv
// Direction type and pin-group bundle shared by port_bus_sequencer and port_connect.
// The sequencer drives dir/data_out through the 'side' modport and samples data_in.
package pocket;
    typedef enum logic {
        DIR_IN  = 1'b0,
        DIR_OUT = 1'b1
    } dir_e;
endpackage

interface port_if #(
    parameter int hi_index = 7,
    parameter int lo_index = 0
);
    pocket::dir_e               dir;
    logic [hi_index-lo_index:0] data_out;
    logic [hi_index-lo_index:0] data_in;

    modport side (output dir, output data_out, input data_in);
    modport pins (input dir, input data_out, output data_in);
endinterface

// File: rtl/port_bus_sequencer.sv
// Sequences single-word reads/writes onto a bidirectional pin group, releasing
// the bus for TURN_CYCLES whenever the drive direction has to flip.
module port_bus_sequencer #(
    parameter int WIDTH         = 8,
    parameter int TURN_CYCLES   = 2,
    parameter int SAMPLE_CYCLES = 3,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             busy,
    port_if.side             port
);
    import pocket::*;

    localparam int MaxTH     = (TURN_CYCLES > HOLD_CYCLES) ? TURN_CYCLES : HOLD_CYCLES;
    localparam int MaxCycles = (MaxTH > SAMPLE_CYCLES) ? MaxTH : SAMPLE_CYCLES;
    localparam int CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    localparam logic [CntW-1:0] TurnLoad   = CntW'(TURN_CYCLES - 1);
    localparam logic [CntW-1:0] SampleLoad = CntW'(SAMPLE_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLoad   = CntW'(HOLD_CYCLES - 1);

    if (TURN_CYCLES < 1 || SAMPLE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_cfg
        $error("port_bus_sequencer: TURN_CYCLES, SAMPLE_CYCLES and HOLD_CYCLES must all be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        DRIVE,
        SETTLE
    } state_e;

    state_e            state_q,    state_d;
    logic [CntW-1:0]   count_q,    count_d;
    dir_e              dir_q,      dir_d;
    logic [WIDTH-1:0]  dataOut_q,  dataOut_d;
    logic [WIDTH-1:0]  wdata_q,    wdata_d;
    logic              isWrite_q,  isWrite_d;
    logic              rspValid_q, rspValid_d;
    logic [WIDTH-1:0]  rspRdata_q, rspRdata_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            dir_q      <= DIR_IN;
            dataOut_q  <= '0;
            wdata_q    <= '0;
            isWrite_q  <= 1'b0;
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            dir_q      <= dir_d;
            dataOut_q  <= dataOut_d;
            wdata_q    <= wdata_d;
            isWrite_q  <= isWrite_d;
            rspValid_q <= rspValid_d;
            rspRdata_q <= rspRdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        dir_d      = dir_q;
        dataOut_d  = dataOut_q;
        wdata_d    = wdata_q;
        isWrite_d  = isWrite_q;
        rspValid_d = 1'b0;
        rspRdata_d = rspRdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    isWrite_d = req_write;
                    wdata_d   = req_wdata;
                    // Bus already parked in the needed direction: skip the turnaround.
                    if (req_write == (dir_q == DIR_OUT)) begin
                        if (req_write) begin
                            state_d   = DRIVE;
                            count_d   = HoldLoad;
                            dataOut_d = req_wdata;
                        end else begin
                            state_d = SETTLE;
                            count_d = SampleLoad;
                        end
                    end else begin
                        state_d = TURN;
                        count_d = TurnLoad;
                        dir_d   = DIR_IN;
                    end
                end
            end
            TURN: begin
                if (count_q == '0) begin
                    if (isWrite_q) begin
                        state_d   = DRIVE;
                        count_d   = HoldLoad;
                        dir_d     = DIR_OUT;
                        dataOut_d = wdata_q;
                    end else begin
                        state_d = SETTLE;
                        count_d = SampleLoad;
                    end
                end else begin
                    count_d = count_q - CntW'(1);
                end
            end
            DRIVE: begin
                if (count_q == '0) begin
                    state_d    = IDLE;
                    rspValid_d = 1'b1;
                end else begin
                    count_d = count_q - CntW'(1);
                end
            end
            SETTLE: begin
                if (count_q == '0) begin
                    state_d    = IDLE;
                    rspValid_d = 1'b1;
                    rspRdata_d = port.data_in;
                end else begin
                    count_d = count_q - CntW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gating with reset_n keeps the requester off until reset has been released.
    assign req_ready     = (state_q == IDLE) && reset_n;
    assign busy          = !req_ready;
    assign rsp_valid     = rspValid_q;
    assign rsp_rdata     = rspRdata_q;
    assign port.dir      = dir_q;
    assign port.data_out = dataOut_q;

endmodule

// File: tb/tb_port_bus_sequencer.sv
// Directed bench for port_bus_sequencer: stimulus pushes expected bus cycles and
// responses into queues; a negedge monitor pops and compares them.
module tb_port_bus_sequencer;
    localparam int WIDTH  = 8;
    localparam int TURN   = 2;
    localparam int SAMPLE = 3;
    localparam int HOLD   = 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic             busy;

    port_if #(.hi_index(WIDTH-1), .lo_index(0)) pif ();

    port_bus_sequencer #(
        .WIDTH(WIDTH),
        .TURN_CYCLES(TURN),
        .SAMPLE_CYCLES(SAMPLE),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .busy(busy),
        .port(pif)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int         cyc;
        logic [7:0] rdata;
        logic       dir;
        logic [7:0] dout;
    } rsp_t;

    typedef struct {
        int         cyc;
        logic       dir;
        logic [7:0] dout;
        bit         chk;
    } bus_t;

    rsp_t rspQ[$];
    bus_t busQ[$];

    int compared   = 0;
    int mismatched = 0;
    int rspSeen    = 0;

    logic       modelDir;
    logic [7:0] modelDataOut;
    logic [7:0] modelRdata;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Issues one request and queues what the bus and response must look like.
    task automatic applyStimulus(input logic write, input logic [7:0] wdata,
                                 input logic [7:0] expRdata, output int issueCycle);
        int n;
        int turn;
        int lat;
        int guard;
        req_valid = 1'b1;
        req_write = write;
        req_wdata = wdata;
        guard     = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checkOutput("acceptTimeout", 32'(req_ready), 32'(1));
            issueCycle = -1;
            @(posedge clk);
            #1 req_valid = 1'b0;
            return;
        end
        n          = cycle;
        issueCycle = n;
        turn       = ((write == 1'b1) != (modelDir == pocket::DIR_OUT)) ? TURN : 0;
        for (int i = 1; i <= turn; i++)
            busQ.push_back('{n + i, pocket::DIR_IN, modelDataOut, !write});
        if (write) begin
            modelDir     = pocket::DIR_OUT;
            modelDataOut = wdata;
            for (int j = 1; j <= HOLD; j++)
                busQ.push_back('{n + turn + j, pocket::DIR_OUT, wdata, 1'b1});
            lat = turn + HOLD;
        end else begin
            modelDir   = pocket::DIR_IN;
            modelRdata = expRdata;
            for (int j = 1; j <= SAMPLE; j++)
                busQ.push_back('{n + turn + j, pocket::DIR_IN, modelDataOut, 1'b1});
            lat = turn + SAMPLE;
        end
        rspQ.push_back('{n + 1 + lat, modelRdata, modelDir, modelDataOut});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        bus_t b;
        rsp_t r;
        while (busQ.size() > 0 && busQ[0].cyc <= cycle) begin
            b = busQ.pop_front();
            checkOutput("busDir", 32'(pif.dir), 32'(b.dir));
            if (b.chk) checkOutput("busDataOut", 32'(pif.data_out), 32'(b.dout));
        end
        if (rsp_valid === 1'b1) begin
            rspSeen++;
            if (rspQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpectedRsp: rsp_valid=1 with nothing outstanding, required 0 (cycle %0d)", cycle);
            end else begin
                r = rspQ.pop_front();
                checkOutput("rspCycle", 32'(cycle), 32'(r.cyc));
                checkOutput("rspRdata", 32'(rsp_rdata), 32'(r.rdata));
                checkOutput("rspDir", 32'(pif.dir), 32'(r.dir));
                checkOutput("rspDataOut", 32'(pif.data_out), 32'(r.dout));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ic;
        int relCycle;
        int guard;
        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_wdata    = '0;
        pif.data_in  = '0;
        modelDir     = pocket::DIR_IN;
        modelDataOut = '0;
        modelRdata   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetDir", 32'(pif.dir), 32'(pocket::DIR_IN));
        checkOutput("resetDataOut", 32'(pif.data_out), 32'(0));
        checkOutput("resetRspValid", 32'(rsp_valid), 32'(0));
        checkOutput("resetRspRdata", 32'(rsp_rdata), 32'(0));
        checkOutput("resetReqReady", 32'(req_ready), 32'(0));
        checkOutput("resetBusy", 32'(busy), 32'(1));
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checkOutput("readyAfterRelease", 32'(req_ready), 32'(1));
        checkOutput("busyAfterRelease", 32'(busy), 32'(0));
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 8'hA5, 8'h00, ic);
        applyStimulus(1'b1, 8'h3C, 8'h00, ic);

        pif.data_in = 8'h5A;
        applyStimulus(1'b0, 8'h00, 8'h5A, ic);
        repeat (TURN + SAMPLE) @(posedge clk);
        #1 pif.data_in = 8'hFF;
        repeat (2) begin
            @(negedge clk);
            checkOutput("rdataHeld", 32'(rsp_rdata), 32'(8'h5A));
        end
        @(posedge clk);
        #1 pif.data_in = 8'h81;
        applyStimulus(1'b0, 8'h00, 8'h81, ic);

        guard = 0;
        while ((rspQ.size() > 0 || busQ.size() > 0) && guard < 40) begin
            @(posedge clk);
            guard++;
        end
        #1;

        req_valid = 1'b1;
        req_write = 1'b1;
        req_wdata = 8'h77;
        guard     = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        checkOutput("turnBusy", 32'(busy), 32'(1));
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midResetDir", 32'(pif.dir), 32'(pocket::DIR_IN));
        checkOutput("midResetDataOut", 32'(pif.data_out), 32'(0));
        checkOutput("midResetRspValid", 32'(rsp_valid), 32'(0));
        checkOutput("midResetRspRdata", 32'(rsp_rdata), 32'(0));
        checkOutput("midResetReqReady", 32'(req_ready), 32'(0));
        modelDir     = pocket::DIR_IN;
        modelDataOut = '0;
        modelRdata   = '0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        relCycle = cycle;
        applyStimulus(1'b1, 8'h77, 8'h00, ic);
        checkOutput("acceptAfterRelease", 32'(ic), 32'(relCycle));

        guard = 0;
        while ((rspQ.size() > 0 || busQ.size() > 0) && guard < 40) begin
            @(posedge clk);
            guard++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rspCount", 32'(rspSeen), 32'(5));
        checkOutput("rspQueueEmpty", 32'(rspQ.size()), 32'(0));
        checkOutput("busQueueEmpty", 32'(busQ.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
